z80_bus_responder: RTL
======================

# z80_bus_responder

Synchronous bus-slave that sits on the external pin side of the Z80 core and answers its bus cycles. It decodes memory read/write, I/O read/write and interrupt-acknowledge cycles and forwards memory/I/O accesses to a simple request/ack backend. It stretches the cycle with nWAIT until the backend answers, then drives read data or the interrupt vector onto D. It also drives nINT from a level interrupt source.

## Interface
Parameters:
- WAIT_CYCLES, 1: minimum edges nWAIT stays low after detection, range 0..15. Counter width is $clog2(WAIT_CYCLES+1), minimum 1.

Ports:
- CLK  in  1  system clock, same clock as the CPU; all logic on the rising edge.
- nRESET  in  1  reset, asynchronous, active-low.
- nM1, nMREQ, nIORQ, nRD, nWR, nRFSH  in  1 each  CPU bus strobes, active-low.
- A  in  16  CPU address.
- d_in  in  8  sampled value of D.
- d_out  out  8  value to drive on D.
- d_oe  out  1  D tristate enable; D = d_oe ? d_out : 'z, applied at the top level.
- nWAIT  out  1  wait request to CPU, active-low, registered.
- nINT  out  1  interrupt request to CPU, active-low, registered.
- bus_req  out  1  one-cycle backend access strobe.
- bus_io  out  1  1 = I/O space, 0 = memory.
- bus_we  out  1  1 = write.
- bus_addr  out  16  latched A.
- bus_wdata  out  8  latched write data.
- bus_rdata  in  8  backend read data, valid with bus_ack.
- bus_ack  in  1  backend completion, one or more cycles.
- irq  in  1  level interrupt source.
- int_vec  in  8  vector returned in INTA.
- int_ack  out  1  one-cycle pulse on INTA detection.

## Operation
- Reset values: d_out=8'h00, d_oe=0, nWAIT=1, nINT=1, bus_req=0, bus_io=0, bus_we=0, bus_addr=0, bus_wdata=0, int_ack=0, state IDLE, ack_seen=0, cnt=0.
- States: IDLE, ACCESS, HOLD.
- Detection happens in IDLE only, on a sampled edge, with the following priority:
  - INTA: nM1=0 and nIORQ=0.
  - IO: nIORQ=0, nM1=1, and (nRD=0 or nWR=0).
  - MEM: nMREQ=0, nRFSH=1, and (nRD=0 or nWR=0).
  - Refresh (nRFSH=0) is ignored.
- MEM/IO detection edge E0:
  - Latch bus_addr=A, bus_we=~nWR, bus_io, and bus_wdata=d_in.
  - bus_req<=1 for exactly one cycle.
  - nWAIT<=0, cnt<=WAIT_CYCLES, ack_seen<=0, go to ACCESS.
- ACCESS, every edge:
  - If bus_ack=1: ack_seen<=1 and, for a read, d_out<=bus_rdata.
  - If cnt!=0: cnt<=cnt-1.
  - Else if bus_ack or ack_seen: nWAIT<=1, d_oe<=~bus_we, go to HOLD.
- INTA detection edge:
  - d_out<=int_vec, d_oe<=1, int_ack<=1 for one cycle.
  - No backend request, no wait states; go to HOLD.
- HOLD: stay until nMREQ=1 and nIORQ=1 are sampled. On that edge d_oe<=0 and state goes to IDLE. d_out holds its last value.
- bus_ack is ignored in IDLE and HOLD. bus_ack sampled at E0 itself is not counted.
- nINT <= ~irq every edge, independent of state.
- Asynchronous reset mid-cycle aborts immediately to reset values, with no completion to the backend.

## Timing
- bus_req is high in the cycle after E0. The backend may assert bus_ack in that same cycle, sampled at E1.
- nWAIT is low from E0 to release edge R, with R = max(E0+WAIT_CYCLES+1, first ack edge+1 if WAIT_CYCLES-driven…) = E0 + max(WAIT_CYCLES, k) + (WAIT_CYCLES>=k ? 1 : 0), where k is the index of the first ack edge.
  - WAIT_CYCLES=0, ack at E1: R=E1.
  - WAIT_CYCLES=1, ack at E1: R=E2.
  - WAIT_CYCLES=1, ack at E4: R=E4.
- Read data and d_oe are valid in the cycle after R and stay until strobes deassert.
- INTA: d_oe and the vector are valid one cycle after detection.
- Back-to-back cycles: a new detection is possible on the edge after the HOLD→IDLE edge.

## Test plan
- Reset: assert nRESET=0 mid-ACCESS with nWAIT low → all outputs return to reset values asynchronously, without waiting for CLK.
- Memory read, WAIT_CYCLES=1, A=16'h1234, backend acks at E1 with 8'hA5 → bus_req pulse with bus_addr=16'h1234, bus_we=0, bus_io=0; nWAIT low 2 cycles; d_oe=1, d_out=8'hA5 until nMREQ/nRD deassert, then d_oe=0.
- I/O write, A=16'h00FE, D=8'h3C, backend acks at E4 → bus_io=1, bus_we=1, bus_wdata=8'h3C; nWAIT released at E4; d_oe stays 0 throughout.
- Interrupt: irq=1 → nINT=0 next edge; INTA cycle with int_vec=8'hFF → int_ack pulse, d_out=8'hFF, d_oe=1; no bus_req.
- Refresh (nMREQ=0, nRFSH=0) → no bus_req, nWAIT stays 1.
- Spurious bus_ack in IDLE, then a read acked at E1 with WAIT_CYCLES=0 → no early release; nWAIT low exactly 1 cycle.

Source files
------------

// File: rtl/z80_bus_responder_if.sv
// Pin-side Z80 bus strobes plus the request/ack backend port, bundled for the responder.
// The slave modport is the responder; the master modport is the CPU together with the backend.
interface z80_bus_responder_if;
  logic        nM1;
  logic        nMREQ;
  logic        nIORQ;
  logic        nRD;
  logic        nWR;
  logic        nRFSH;
  logic [15:0] A;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic        d_oe;
  logic        nWAIT;
  logic        nINT;
  logic        bus_req;
  logic        bus_io;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_ack;
  logic        irq;
  logic [7:0]  int_vec;
  logic        int_ack;

  modport slave (
    input  nM1, nMREQ, nIORQ, nRD, nWR, nRFSH, A, d_in, bus_rdata, bus_ack, irq, int_vec,
    output d_out, d_oe, nWAIT, nINT, bus_req, bus_io, bus_we, bus_addr, bus_wdata, int_ack
  );

  modport master (
    output nM1, nMREQ, nIORQ, nRD, nWR, nRFSH, A, d_in, bus_rdata, bus_ack, irq, int_vec,
    input  d_out, d_oe, nWAIT, nINT, bus_req, bus_io, bus_we, bus_addr, bus_wdata, int_ack
  );
endinterface

// File: rtl/z80_bus_responder.sv
// Z80 pin-side bus slave: decodes MEM/IO/INTA cycles, stretches them with nWAIT
// until the backend acks, then drives read data or the interrupt vector onto D.
//
// state  | meaning
// IDLE   | waiting for a MEM, IO or INTA cycle to start
// ACCESS | backend request issued, nWAIT held low until min wait and ack are both met
// HOLD   | cycle answered, waiting for nMREQ and nIORQ to both go high
module z80_bus_responder #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              nRESET,
  z80_bus_responder_if.slave bus
);

  localparam int CntW = ($clog2(WAIT_CYCLES + 1) < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CntW-1:0] WaitInit = CntW'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t          state;
  logic            ackSeen;
  logic [CntW-1:0] cnt;
  logic            detInta;
  logic            detIo;
  logic            detMem;

  // INTA outranks IO because an acknowledge also pulls nIORQ low.
  assign detInta = !bus.nM1 && !bus.nIORQ;
  assign detIo   = !bus.nIORQ && bus.nM1 && (!bus.nRD || !bus.nWR);
  assign detMem  = !bus.nMREQ && bus.nRFSH && (!bus.nRD || !bus.nWR);

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state         <= IDLE;
      ackSeen       <= 1'b0;
      cnt           <= '0;
      bus.d_out     <= 8'h00;
      bus.d_oe      <= 1'b0;
      bus.nWAIT     <= 1'b1;
      bus.nINT      <= 1'b1;
      bus.bus_req   <= 1'b0;
      bus.bus_io    <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= 16'h0000;
      bus.bus_wdata <= 8'h00;
      bus.int_ack   <= 1'b0;
    end else begin
      bus.bus_req <= 1'b0;
      bus.int_ack <= 1'b0;
      bus.nINT    <= ~bus.irq;
      case (state)
        IDLE: begin
          if (detInta) begin
            bus.d_out   <= bus.int_vec;
            bus.d_oe    <= 1'b1;
            bus.int_ack <= 1'b1;
            state       <= HOLD;
          end else if (detIo || detMem) begin
            bus.bus_addr  <= bus.A;
            bus.bus_we    <= ~bus.nWR;
            bus.bus_io    <= detIo;
            bus.bus_wdata <= bus.d_in;
            bus.bus_req   <= 1'b1;
            bus.nWAIT     <= 1'b0;
            cnt           <= WaitInit;
            ackSeen       <= 1'b0;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          if (bus.bus_ack) begin
            ackSeen <= 1'b1;
            if (!bus.bus_we) bus.d_out <= bus.bus_rdata;
          end
          // The minimum wait must expire before an ack (current or remembered) can release.
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (bus.bus_ack || ackSeen) begin
            bus.nWAIT <= 1'b1;
            bus.d_oe  <= ~bus.bus_we;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (bus.nMREQ && bus.nIORQ) begin
            bus.d_oe <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
